ed_alif_sweep_scheduler: RTL and testbench
==========================================

Name: ed_alif_sweep_scheduler

Overview:
Time-multiplexed sequencer for one shared ALIF neuron datapath serving N_NEURONS logical neurons.
- On each global timestep tick, sweeps neuron indices 0..N_NEURONS-1 and drives the datapath's enable, input_event and refract_cnt controls.
- Latches incoming synaptic events in a pending bitmap and owns the per-neuron refractory counters.
- Forwards datapath spikes to the fabric through a valid/ready output.
- State (V/W) memory addressing uses nrn_idx and is external to this block.

Parameters:
N_NEURONS, 16, number of logical neurons swept per tick (2..256)
IDX_WIDTH, $clog2(N_NEURONS), neuron index width
REFRACT_PERIOD, 4'd3, refractory load value after a spike (0..15; 0 disables refractoriness)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
tick  in  1  timestep start pulse
busy  out  1  high while a sweep is in progress
sweep_done  out  1  one-cycle pulse after the last neuron is serviced
tick_overrun  out  1  one-cycle pulse when tick arrives while not IDLE
evt_valid  in  1  synaptic event valid
evt_idx  in  IDX_WIDTH  target neuron of event
evt_ready  out  1  event accept
nrn_idx  out  IDX_WIDTH  neuron currently serviced
nrn_enable  out  1  datapath enable (one cycle per neuron)
nrn_input_event  out  1  pending-event flag of nrn_idx
nrn_refract_cnt  out  4  refractory count of nrn_idx
nrn_spike  in  1  datapath spike, same cycle as nrn_enable
spk_valid  out  1  spike output valid
spk_idx  out  IDX_WIDTH  index of spiking neuron
spk_ready  in  1  spike output accept

Behaviour:
Reset (rst_n=0 at clk edge):
- FSM to IDLE; all outputs 0 except evt_ready=1 from the first cycle after reset.
- Pending bitmap, all refractory counters and spike register cleared.
- Reset mid-sweep abandons the sweep with no sweep_done.

FSM IDLE -> SWEEP -> DONE -> IDLE:
- IDLE: tick=1 moves to SWEEP, idx counter=0.
- SWEEP: busy=1. One issue per cycle when slot_ok = (!spk_valid || spk_ready).
  - If slot_ok: nrn_enable=1, nrn_idx=idx.
  - If !slot_ok: nrn_enable=0, idx held (stall). Every issued neuron is therefore guaranteed a spike slot.
  - After issuing idx=N_NEURONS-1, go to DONE.
- DONE: sweep_done=1 for one cycle, busy=0, return to IDLE.
- Timing: minimum tick-to-sweep_done is N_NEURONS+1 cycles; the first enable occurs the cycle after tick.
- tick while in SWEEP or DONE: ignored, tick_overrun=1 that cycle.

Combinational controls:
- nrn_input_event = pending[idx] & nrn_enable.
- nrn_refract_cnt = rcnt[idx]; valid only while nrn_enable=1.

Refractory counter update, on an issue cycle for idx:
- nrn_spike=1: rcnt[idx] <= REFRACT_PERIOD.
- else if rcnt[idx]!=0: rcnt[idx] decrements by 1, saturating at 0.
- Not issued this tick: counter unchanged.

Pending bitmap:
- evt_ready is constantly 1 out of reset; evt_valid sets pending[evt_idx] in any state.
- On an issue cycle, pending[idx] is cleared.
- Same-cycle set and clear for the same idx: set wins. The event is delivered on the next tick, and the current issue still sees the old bit.
- evt_idx >= N_NEURONS is dropped silently.
- Duplicate events before service merge into one.

Spike output:
- Single-entry register. nrn_spike=1 on an issue cycle loads spk_idx=idx, spk_valid=1 next cycle.
- spk_valid stays asserted until spk_ready.
- Drain and reload in the same cycle are allowed (back-to-back spikes, no bubble).
- spk_idx is stable while spk_valid & !spk_ready.
- nrn_spike is ignored when nrn_enable=0.

Test Plan:
1. N_NEURONS=4, spk_ready=1, no events, nrn_spike=0; tick -> nrn_enable on 4 consecutive cycles with nrn_idx 0,1,2,3; sweep_done 5 cycles after tick; busy high 4 cycles.
2. evt_idx=2 before tick; second event evt_idx=2 on the cycle idx=2 is issued -> nrn_input_event=1 only at idx=2 this sweep, pending[2] remains set, nrn_input_event=1 at idx=2 on the next tick.
3. nrn_spike=1 at idx=1, REFRACT_PERIOD=3 -> spk_valid with spk_idx=1 next cycle; nrn_refract_cnt at idx=1 reads 3, 2, 1, 0 on ticks 2..5.
4. spk_ready=0 with spikes at idx=0 and idx=1 -> idx=1 not issued (nrn_enable=0, nrn_idx=1 held) until spk_ready=1; spk_idx=0 held stable; then spk_idx=1 follows with no lost spike.
5. tick during SWEEP -> tick_overrun pulse, sweep count unchanged, exactly one sweep_done.
6. rst_n=0 at idx=2 mid-sweep -> next cycle busy=0, spk_valid=0, all counters and pending bits 0, no sweep_done; a following tick sweeps from idx 0.

Source files
------------

// File: rtl/ed_alif_sweep_scheduler_if.sv
// Control bundle between the ALIF sweep scheduler, the event fabric and the shared neuron datapath.
interface ed_alif_sweep_scheduler_if #(
    parameter int N_NEURONS = 16,
    parameter int IDX_WIDTH = $clog2(N_NEURONS)
);
    logic                 tick;
    logic                 busy;
    logic                 sweep_done;
    logic                 tick_overrun;
    logic                 evt_valid;
    logic [IDX_WIDTH-1:0] evt_idx;
    logic                 evt_ready;
    logic [IDX_WIDTH-1:0] nrn_idx;
    logic                 nrn_enable;
    logic                 nrn_input_event;
    logic [3:0]           nrn_refract_cnt;
    logic                 nrn_spike;
    logic                 spk_valid;
    logic [IDX_WIDTH-1:0] spk_idx;
    logic                 spk_ready;

    modport master (
        input  tick, evt_valid, evt_idx, nrn_spike, spk_ready,
        output busy, sweep_done, tick_overrun, evt_ready, nrn_idx, nrn_enable,
               nrn_input_event, nrn_refract_cnt, spk_valid, spk_idx
    );

    modport slave (
        output tick, evt_valid, evt_idx, nrn_spike, spk_ready,
        input  busy, sweep_done, tick_overrun, evt_ready, nrn_idx, nrn_enable,
               nrn_input_event, nrn_refract_cnt, spk_valid, spk_idx
    );
endinterface

// File: rtl/ed_alif_sweep_scheduler.sv
// Sweeps N_NEURONS logical neurons through one shared ALIF datapath per tick, owning the
// pending-event bitmap, refractory counters and a single-entry spike output register.
module ed_alif_sweep_scheduler #(
    parameter int         N_NEURONS      = 16,
    parameter int         IDX_WIDTH      = $clog2(N_NEURONS),
    parameter logic [3:0] REFRACT_PERIOD = 4'd3
) (
    input logic                       clk,
    input logic                       rst_n,
    ed_alif_sweep_scheduler_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_NEURONS - 1);

    state_t                    r_state;
    logic [IDX_WIDTH-1:0]      r_idx;
    logic                      r_busy;
    logic                      r_sweep_done;
    logic [N_NEURONS-1:0]      r_pend;
    logic [N_NEURONS-1:0][3:0] r_rcnt;
    logic                      r_spk_valid;
    logic [IDX_WIDTH-1:0]      r_spk_idx;

    logic w_slot_ok;
    logic w_issue;
    logic w_evt_ok;

    // Issue only when the spike register can take a result, so no spike is ever dropped.
    assign w_slot_ok = !r_spk_valid || bus.spk_ready;
    assign w_issue   = (r_state == S_SWEEP) && w_slot_ok;
    assign w_evt_ok  = bus.evt_valid && (32'(bus.evt_idx) < N_NEURONS);

    assign bus.busy            = r_busy;
    assign bus.sweep_done      = r_sweep_done;
    assign bus.tick_overrun    = bus.tick && (r_state != S_IDLE);
    assign bus.evt_ready       = 1'b1;
    assign bus.nrn_idx         = r_idx;
    assign bus.nrn_enable      = w_issue;
    assign bus.nrn_input_event = r_pend[r_idx] & w_issue;
    assign bus.nrn_refract_cnt = r_rcnt[r_idx];
    assign bus.spk_valid       = r_spk_valid;
    assign bus.spk_idx         = r_spk_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.tick) begin
                        r_state <= S_SWEEP;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (w_slot_ok) begin
                        if (r_idx == LAST_IDX) begin
                            r_state      <= S_DONE;
                            r_idx        <= '0;
                            r_busy       <= 1'b0;
                            r_sweep_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_WIDTH'(1);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_rcnt      <= '0;
            r_spk_valid <= 1'b0;
            r_spk_idx   <= '0;
        end else begin
            if (w_issue) begin
                r_pend[r_idx] <= 1'b0;
                if (bus.nrn_spike)
                    r_rcnt[r_idx] <= REFRACT_PERIOD;
                else if (r_rcnt[r_idx] != 4'd0)
                    r_rcnt[r_idx] <= r_rcnt[r_idx] - 4'd1;
            end
            // Placed after the issue clear so a same-cycle event survives to the next tick.
            if (w_evt_ok)
                r_pend[bus.evt_idx] <= 1'b1;
            if (w_issue && bus.nrn_spike) begin
                r_spk_valid <= 1'b1;
                r_spk_idx   <= r_idx;
            end else if (bus.spk_ready) begin
                r_spk_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ed_alif_sweep_scheduler.sv
// Bench for ed_alif_sweep_scheduler: directed scenarios plus randomized traffic against a neuron-level model.
module tb_ed_alif_sweep_scheduler;
    localparam int N   = 6;
    localparam int IW  = 3;
    localparam int REF = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: sweep phase, next neuron to serve, per-neuron pending/refractory, spike slot.
    bit m_sweep, m_done, m_sv;
    int m_idx, m_si;
    bit m_pend[N];
    int m_rcnt[N];

    always #5 clk = ~clk;

    ed_alif_sweep_scheduler_if #(.N_NEURONS(N), .IDX_WIDTH(IW)) bus ();

    ed_alif_sweep_scheduler #(.N_NEURONS(N), .IDX_WIDTH(IW), .REFRACT_PERIOD(4'd3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic model_update();
        bit iss;
        if (!rst_n) begin
            m_sweep = 0; m_done = 0; m_idx = 0; m_sv = 0; m_si = 0;
            for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_rcnt[k] = 0; end
            return;
        end
        iss = m_sweep && (!m_sv || bus.spk_ready);
        if (iss) begin
            m_pend[m_idx] = 0;
            if (bus.nrn_spike) m_rcnt[m_idx] = REF;
            else if (m_rcnt[m_idx] > 0) m_rcnt[m_idx] = m_rcnt[m_idx] - 1;
        end
        if (iss && bus.nrn_spike) begin m_sv = 1; m_si = m_idx; end
        else if (bus.spk_ready) m_sv = 0;
        if (bus.evt_valid && int'(bus.evt_idx) < N) m_pend[bus.evt_idx] = 1;
        if (m_done) m_done = 0;
        else if (m_sweep) begin
            if (iss) begin
                if (m_idx == N - 1) begin m_sweep = 0; m_done = 1; m_idx = 0; end
                else m_idx = m_idx + 1;
            end
        end else if (bus.tick) begin
            m_sweep = 1; m_idx = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run_sweep(input logic [N-1:0] mask, output logic [N-1:0] ie,
                             output logic [N-1:0][3:0] rc, output int en_cnt, output int done_cnt);
        ie = '0; rc = '0; en_cnt = 0; done_cnt = 0;
        bus.tick = 1; step(); bus.tick = 0;
        for (int c = 0; c < 8 * N; c++) begin
            #1;
            if (bus.sweep_done) begin done_cnt++; bus.nrn_spike = 0; step(); break; end
            if (bus.nrn_enable) begin
                en_cnt++;
                ie[bus.nrn_idx] = bus.nrn_input_event;
                rc[bus.nrn_idx] = bus.nrn_refract_cnt;
                bus.nrn_spike = mask[bus.nrn_idx];
            end else bus.nrn_spike = 0;
            step();
        end
        bus.nrn_spike = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; step(); bus.tick = 1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.sweep_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.sweep_done); end
        checks++; if (bus.nrn_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%0b exp=0", bus.nrn_enable); end
        checks++; if (bus.spk_valid !== 1'b0) begin failures++; $display("FAIL reset_spk_valid got=%0b exp=0", bus.spk_valid); end
        checks++; if (bus.evt_ready !== 1'b1) begin failures++; $display("FAIL reset_evt_ready got=%0b exp=1", bus.evt_ready); end
        checks++; if (bus.tick_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", bus.tick_overrun); end
        checks++; if (bus.nrn_refract_cnt !== 4'd0) begin failures++; $display("FAIL reset_rcnt got=%0d exp=0", bus.nrn_refract_cnt); end
        bus.tick = 0; step();
        rst_n = 1; step();
    endtask

    task automatic test_basic_sweep();
        int en, busy_c, done_at;
        bit order_ok;
        en = 0; busy_c = 0; done_at = -1; order_ok = 1;
        bus.spk_ready = 1; bus.tick = 1;
        #1;
        checks++; if (bus.tick_overrun !== 1'b0) begin failures++; $display("FAIL basic_idle_overrun got=%0b exp=0", bus.tick_overrun); end
        step(); bus.tick = 0;
        for (int c = 1; c <= N + 3; c++) begin
            #1;
            if (bus.busy) busy_c++;
            if (bus.nrn_enable) begin
                if (bus.nrn_idx !== IW'(en) || c != en + 1) order_ok = 0;
                en++;
            end
            if (bus.sweep_done) done_at = (done_at < 0) ? c : 99;
            step();
        end
        checks++; if (en != N) begin failures++; $display("FAIL basic_enable_count got=%0d exp=%0d", en, N); end
        checks++; if (!order_ok) begin failures++; $display("FAIL basic_idx_order got=0 exp=1"); end
        checks++; if (done_at != N + 1) begin failures++; $display("FAIL basic_done_latency got=%0d exp=%0d", done_at, N + 1); end
        checks++; if (busy_c != N) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_c, N); end
    endtask

    task automatic test_event_merge();
        logic [N-1:0] ie;
        logic [N-1:0][3:0] rc;
        int en, dn, bad;
        bit seen2;
        bus.evt_valid = 1; bus.evt_idx = 3'd2; step(); step();
        bus.evt_idx = 3'd7; step(); bus.evt_idx = 3'd6; step(); bus.evt_valid = 0;
        bus.tick = 1; step(); bus.tick = 0;
        bad = 0; seen2 = 0; dn = 0;
        for (int c = 0; c < 8 * N; c++) begin
            #1;
            bus.evt_valid = 0;
            if (bus.sweep_done) begin dn++; step(); break; end
            if (bus.nrn_enable) begin
                if (bus.nrn_idx == 3'd2) begin
                    seen2 = bus.nrn_input_event; bus.evt_valid = 1; bus.evt_idx = 3'd2;
                end else if (bus.nrn_input_event !== 1'b0) bad++;
            end
            step();
        end
        bus.evt_valid = 0;
        checks++; if (seen2 !== 1'b1) begin failures++; $display("FAIL evt_idx2_seen got=%0b exp=1", seen2); end
        checks++; if (bad != 0) begin failures++; $display("FAIL evt_other_idx got=%0d exp=0", bad); end
        checks++; if (dn != 1) begin failures++; $display("FAIL evt_sweep_done got=%0d exp=1", dn); end
        run_sweep('0, ie, rc, en, dn);
        checks++; if (ie !== 6'b000100) begin failures++; $display("FAIL evt_redelivered got=%b exp=000100", ie); end
        run_sweep('0, ie, rc, en, dn);
        checks++; if (ie !== 6'b000000) begin failures++; $display("FAIL evt_cleared got=%b exp=000000", ie); end
    endtask

    task automatic test_refract();
        logic [N-1:0] ie;
        logic [N-1:0][3:0] rc;
        int en, dn, got_i;
        bit armed, got_v;
        armed = 0; got_v = 0; got_i = -1; dn = 0;
        bus.tick = 1; step(); bus.tick = 0;
        for (int c = 0; c < 8 * N; c++) begin
            #1;
            if (armed) begin got_v = bus.spk_valid; got_i = int'(bus.spk_idx); armed = 0; end
            if (bus.sweep_done) begin dn++; bus.nrn_spike = 0; step(); break; end
            bus.nrn_spike = bus.nrn_enable && (bus.nrn_idx == 3'd1);
            if (bus.nrn_spike) armed = 1;
            step();
        end
        bus.nrn_spike = 0;
        checks++; if (got_v !== 1'b1) begin failures++; $display("FAIL refr_spk_valid got=%0b exp=1", got_v); end
        checks++; if (got_i != 1) begin failures++; $display("FAIL refr_spk_idx got=%0d exp=1", got_i); end
        for (int k = 0; k < 4; k++) begin
            run_sweep('0, ie, rc, en, dn);
            checks++;
            if (int'(rc[1]) != REF - k || dn != 1) begin
                failures++; $display("FAIL refr_count_tick%0d got=%0d exp=%0d done=%0d", k + 2, rc[1], REF - k, dn);
            end
        end
    endtask

    task automatic test_stall();
        int dn;
        dn = 0;
        bus.spk_ready = 0; bus.tick = 1; step(); bus.tick = 0;
        #1;
        checks++; if (bus.nrn_enable !== 1'b1 || bus.nrn_idx !== 3'd0) begin
            failures++; $display("FAIL stall_first_issue got=%0b/%0d exp=1/0", bus.nrn_enable, bus.nrn_idx); end
        bus.nrn_spike = 1; step();
        for (int r = 0; r < 3; r++) begin
            #1;
            checks++; if (bus.nrn_enable !== 1'b0 || bus.nrn_idx !== 3'd1) begin
                failures++; $display("FAIL stall_hold got=%0b/%0d exp=0/1", bus.nrn_enable, bus.nrn_idx); end
            checks++; if (bus.spk_valid !== 1'b1 || bus.spk_idx !== 3'd0) begin
                failures++; $display("FAIL stall_spk_stable got=%0b/%0d exp=1/0", bus.spk_valid, bus.spk_idx); end
            bus.nrn_spike = 1; step();
        end
        bus.nrn_spike = 0; bus.spk_ready = 1;
        #1;
        checks++; if (bus.nrn_enable !== 1'b1 || bus.nrn_idx !== 3'd1) begin
            failures++; $display("FAIL stall_resume got=%0b/%0d exp=1/1", bus.nrn_enable, bus.nrn_idx); end
        bus.nrn_spike = 1; step(); bus.nrn_spike = 0;
        #1;
        checks++; if (bus.spk_valid !== 1'b1 || bus.spk_idx !== 3'd1) begin
            failures++; $display("FAIL stall_back_to_back got=%0b/%0d exp=1/1", bus.spk_valid, bus.spk_idx); end
        for (int c = 0; c < 8 * N; c++) begin
            if (c > 0) #1;
            if (bus.sweep_done) begin dn++; step(); break; end
            step();
        end
        checks++; if (dn != 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", dn); end
    endtask

    task automatic test_overrun();
        int en, dn, extra;
        bit ovr_mid, ovr_done;
        en = 0; dn = 0; extra = 0; ovr_mid = 0; ovr_done = 0;
        bus.tick = 1; step(); bus.tick = 0;
        #1; if (bus.nrn_enable) en++;
        step();
        bus.tick = 1;
        #1; ovr_mid = bus.tick_overrun; if (bus.nrn_enable) en++;
        step(); bus.tick = 0;
        for (int c = 0; c < 8 * N; c++) begin
            #1;
            if (bus.sweep_done) begin
                dn++; bus.tick = 1; #1; ovr_done = bus.tick_overrun; step(); bus.tick = 0; break;
            end
            if (bus.nrn_enable) en++;
            step();
        end
        for (int c = 0; c < 3; c++) begin
            #1; if (bus.busy || bus.nrn_enable) extra++; if (bus.sweep_done) dn++;
            step();
        end
        checks++; if (ovr_mid !== 1'b1) begin failures++; $display("FAIL ovr_in_sweep got=%0b exp=1", ovr_mid); end
        checks++; if (ovr_done !== 1'b1) begin failures++; $display("FAIL ovr_in_done got=%0b exp=1", ovr_done); end
        checks++; if (en != N) begin failures++; $display("FAIL ovr_enable_count got=%0d exp=%0d", en, N); end
        checks++; if (dn != 1) begin failures++; $display("FAIL ovr_done_count got=%0d exp=1", dn); end
        checks++; if (extra != 0) begin failures++; $display("FAIL ovr_no_restart got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ie;
        logic [N-1:0][3:0] rc;
        int en, dn, bad;
        bit hit;
        hit = 0; bad = 0;
        bus.evt_valid = 1; bus.evt_idx = 3'd4; step(); bus.evt_valid = 0;
        bus.tick = 1; step(); bus.tick = 0;
        for (int c = 0; c < 8 * N; c++) begin
            #1;
            bus.nrn_spike = bus.nrn_enable && (bus.nrn_idx == 3'd0);
            if (bus.nrn_enable && bus.nrn_idx == 3'd2) begin
                bus.nrn_spike = 1; rst_n = 0; hit = 1; step(); rst_n = 1; break;
            end
            step();
        end
        bus.nrn_spike = 0;
        checks++; if (!hit) begin failures++; $display("FAIL rstmid_reached got=0 exp=1"); end
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.spk_valid !== 1'b0 || bus.nrn_enable !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs got=%0b%0b%0b exp=000", bus.busy, bus.spk_valid, bus.nrn_enable); end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) #1;
            if (bus.sweep_done || bus.busy) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", bad); end
        run_sweep('0, ie, rc, en, dn);
        checks++; if (ie !== '0) begin failures++; $display("FAIL rstmid_pending got=%b exp=000000", ie); end
        checks++; if (rc !== '0) begin failures++; $display("FAIL rstmid_rcnt got=%h exp=0", rc); end
        checks++; if (en != N || dn != 1) begin failures++; $display("FAIL rstmid_resweep got=%0d/%0d exp=%0d/1", en, dn, N); end
    endtask

    task automatic test_random();
        bit e_en;
        for (int c = 0; c < 3000 && failures < 30; c++) begin
            rst_n         = ($urandom_range(0, 399) != 0);
            bus.tick      = ($urandom_range(0, 14) == 0);
            bus.evt_valid = ($urandom_range(0, 2) == 0);
            bus.evt_idx   = IW'($urandom_range(0, 7));
            bus.spk_ready = ($urandom_range(0, 3) != 0);
            bus.nrn_spike = ($urandom_range(0, 2) == 0);
            #1;
            e_en = m_sweep && (!m_sv || bus.spk_ready);
            checks++; if (bus.busy !== m_sweep) begin failures++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, bus.busy, m_sweep); end
            checks++; if (bus.sweep_done !== m_done) begin failures++; $display("FAIL rnd_done c=%0d got=%0b exp=%0b", c, bus.sweep_done, m_done); end
            checks++; if (bus.tick_overrun !== (bus.tick && (m_sweep || m_done))) begin
                failures++; $display("FAIL rnd_overrun c=%0d got=%0b", c, bus.tick_overrun); end
            checks++; if (bus.nrn_enable !== e_en) begin failures++; $display("FAIL rnd_enable c=%0d got=%0b exp=%0b", c, bus.nrn_enable, e_en); end
            if (e_en) begin
                checks++; if (bus.nrn_idx !== IW'(m_idx)) begin failures++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, bus.nrn_idx, m_idx); end
                checks++; if (bus.nrn_input_event !== m_pend[m_idx]) begin
                    failures++; $display("FAIL rnd_input_event c=%0d got=%0b exp=%0b", c, bus.nrn_input_event, m_pend[m_idx]); end
                checks++; if (bus.nrn_refract_cnt !== 4'(m_rcnt[m_idx])) begin
                    failures++; $display("FAIL rnd_rcnt c=%0d got=%0d exp=%0d", c, bus.nrn_refract_cnt, m_rcnt[m_idx]); end
            end
            checks++; if (bus.spk_valid !== m_sv) begin failures++; $display("FAIL rnd_spk_valid c=%0d got=%0b exp=%0b", c, bus.spk_valid, m_sv); end
            if (m_sv) begin
                checks++; if (bus.spk_idx !== IW'(m_si)) begin failures++; $display("FAIL rnd_spk_idx c=%0d got=%0d exp=%0d", c, bus.spk_idx, m_si); end
            end
            step();
        end
        rst_n = 1; bus.tick = 0; bus.evt_valid = 0; bus.nrn_spike = 0; bus.spk_ready = 1;
        step();
    endtask

    initial begin
        rst_n = 0; bus.tick = 0; bus.evt_valid = 0; bus.evt_idx = '0; bus.nrn_spike = 0; bus.spk_ready = 1;
        test_reset();
        test_basic_sweep();
        test_event_merge();
        test_refract();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
